// File: rtl/_sipo_shift_reg_pkg.sv
// rtl/_sipo_shift_reg_pkg.sv - shared FSM encoding and width helper for the SIPO assembler
package _sipo_shift_reg_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } sipo_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Counter width for an arbitrary word size
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/_sipo_bit_counter.sv
// rtl/_sipo_bit_counter.sv - mod-WIDTH beat counter, flags the final bit of a word
module _sipo_bit_counter
  import _sipo_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = sipo_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/_sipo_shift_reg.sv
// rtl/_sipo_shift_reg.sv - serial-in/parallel-out word assembler with valid/ready output
module _sipo_shift_reg
  import _sipo_shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = sipo_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CW-1:0]    bit_cnt
);

  sipo_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_next;
  logic             accept, take, cnt_last;

  assign accept = s_valid & s_ready & ~clr;
  assign take   = m_valid & m_ready & ~clr;

  _sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (accept),
    .cnt   (bit_cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: if (accept && cnt_last) state_d = FULL;
        FULL: if (take) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // In FULL, s_ready follows m_ready so a take and a new first bit share a cycle
  always_comb begin
    m_valid = (state_q == FULL);
    s_ready = 1'b0;
    if (!reset) begin
      s_ready = (state_q == FILL) ? 1'b1 : m_ready;
    end
  end

  always_comb begin
    shift_next = shift_q;
    if (MSB_FIRST) begin
      shift_next = {shift_q[WIDTH-2:0], s_bit};
    end else begin
      shift_next = {s_bit, shift_q[WIDTH-1:1]};
    end
  end

  // Shift register is cleared on word completion so a beat accepted in FULL starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      m_data  <= '0;
    end else if (clr) begin
      shift_q <= '0;
    end else if (accept) begin
      if (state_q == FILL && cnt_last) begin
        m_data  <= shift_next;
        shift_q <= '0;
      end else begin
        shift_q <= shift_next;
      end
    end
  end

endmodule

// File: tb/tb__sipo_shift_reg.sv
// tb/tb__sipo_shift_reg.sv - directed self-checking bench for the SIPO assembler
module tb__sipo_shift_reg;

  logic       clk = 1'b0;
  logic       reset, clr, s_valid, s_bit, m_ready;
  logic       s_ready_a, m_valid_a, s_ready_b, m_valid_b;
  logic [7:0] m_data_a, m_data_b;
  logic [2:0] bit_cnt_a, bit_cnt_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  _sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .clr(clr), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready_a), .m_valid(m_valid_a), .m_data(m_data_a),
    .m_ready(m_ready), .bit_cnt(bit_cnt_a)
  );

  _sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .clr(clr), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready_b), .m_valid(m_valid_b), .m_data(m_data_b),
    .m_ready(m_ready), .bit_cnt(bit_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr = 1'b0; s_valid = 1'b0; s_bit = 1'b0; m_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_ready_a !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready_a); end
    s_valid = 1'b1; s_bit = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bit_cnt_a !== 3'd3) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=3", bit_cnt_a); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({s_ready_a, m_valid_a, m_data_a, bit_cnt_a} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b/%b/%h/%0d exp=0/0/00/0", s_ready_a, m_valid_a, m_data_a, bit_cnt_a);
    end
    s_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (s_ready_a !== 1'b1) begin failures++; $display("FAIL release_s_ready got=%b exp=1", s_ready_a); end
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat = 8'hB2;
    do_reset();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      s_bit = pat[i];
      tick();
      if (i > 0) begin
        checks++;
        if (m_valid_a !== 1'b0) begin failures++; $display("FAIL single_early_valid bit=%0d got=%b exp=0", i, m_valid_a); end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 8'hB2 || bit_cnt_a !== 3'd0) begin
      failures++;
      $display("FAIL single_word got=%b/%h/%0d exp=1/b2/0", m_valid_a, m_data_a, bit_cnt_a);
    end
    tick();
    checks++;
    if (m_valid_a !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", m_valid_a); end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    pat = 8'hB2;
    do_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      s_bit = pat[i];
      tick();
    end
    s_bit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (s_ready_a !== 1'b0 || m_valid_a !== 1'b1 || m_data_a !== 8'hB2 || bit_cnt_a !== 3'd0) begin
        failures++;
        $display("FAIL hold cyc=%0d got=%b/%b/%h/%0d exp=0/1/b2/0", c, s_ready_a, m_valid_a, m_data_a, bit_cnt_a);
      end
      tick();
    end
    m_ready = 1'b1; s_bit = 1'b1;
    #1;
    checks++;
    if (s_ready_a !== 1'b1) begin failures++; $display("FAIL bubble_free_ready got=%b exp=1", s_ready_a); end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid_a !== 1'b0 || bit_cnt_a !== 3'd1) begin
      failures++;
      $display("FAIL take_and_beat got=%b/%0d exp=0/1", m_valid_a, bit_cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'hB24D;
    do_reset();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      s_bit = pat[i];
      tick();
      if (i == 8) begin
        checks++;
        if (m_valid_a !== 1'b1 || m_data_a !== 8'hB2) begin
          failures++; $display("FAIL b2b_word0 got=%b/%h exp=1/b2", m_valid_a, m_data_a);
        end
      end
      if (i == 7) begin
        checks++;
        if (m_valid_a !== 1'b0 || bit_cnt_a !== 3'd1) begin
          failures++; $display("FAIL b2b_full_beat got=%b/%0d exp=0/1", m_valid_a, bit_cnt_a);
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 8'h4D) begin
      failures++; $display("FAIL b2b_word1 got=%b/%h exp=1/4d", m_valid_a, m_data_a);
    end
    tick();
  endtask

  task automatic test_clr();
    logic [4:0] part;
    part = 5'b01010;
    do_reset();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      s_bit = part[i];
      tick();
    end
    clr = 1'b1; s_bit = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bit_cnt_a !== 3'd0 || m_valid_a !== 1'b0) begin
      failures++; $display("FAIL clr_state got=%0d/%b exp=0/0", bit_cnt_a, m_valid_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) begin
        checks++;
        if (m_valid_a !== 1'b0) begin failures++; $display("FAIL clr_stale_count got=%b exp=0", m_valid_a); end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 8'hFF) begin
      failures++; $display("FAIL clr_word got=%b/%h exp=1/ff", m_valid_a, m_data_a);
    end
    tick();
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    pat = 8'hB2;
    do_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_bit = pat[i];
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid_b !== 1'b1 || m_data_b !== 8'hB2) begin
      failures++; $display("FAIL lsb_word got=%b/%h exp=1/b2", m_valid_b, m_data_b);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (m_valid_b !== 1'b0 || m_data_b !== 8'h00) begin
      failures++; $display("FAIL reset_in_full got=%b/%h exp=0/00", m_valid_b, m_data_b);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
